// File: rtl/dmi_sb_responder.sv
// rtl/dmi_sb_responder.sv - DMI debug-module responder with a 32-bit system-bus master.
// Optional macro DMI_SB_TIMEOUT_EN aborts a stalled system-bus transfer after SB_TIMEOUT cycles.
module dmi_sb_responder #(
  parameter logic [31:0] DMSTATUS_VAL = 32'h0000_0C82,
  parameter int          SB_TIMEOUT   = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        creq_vld,
  input  logic [40:0] creq_data,
  output logic        creq_rdy,
  output logic        cresp_vld,
  output logic [33:0] cresp_data,
  input  logic        cresp_rdy,
  output logic        waen,
  output logic [31:0] waddr,
  output logic        wden,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  input  logic        wardy,
  input  logic        wdrdy,
  input  logic        wbvld,
  output logic        raen,
  output logic [31:0] raddr,
  output logic        rden,
  input  logic [31:0] rdata,
  input  logic        rardy,
  input  logic        rdrdy
);

  localparam logic [6:0] A_DMCONTROL = 7'h10;
  localparam logic [6:0] A_DMSTATUS  = 7'h11;
  localparam logic [6:0] A_SBCS      = 7'h38;
  localparam logic [6:0] A_SBADDR0   = 7'h39;
  localparam logic [6:0] A_SBDATA0   = 7'h3C;
  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {DMI_IDLE, DMI_EXEC, DMI_RESP} dmi_state_t;
  typedef enum logic [2:0] {SB_IDLE, SB_WR, SB_WRESP, SB_RD_A, SB_RD_D} sb_state_t;

  dmi_state_t dmi_state, dmi_next;
  sb_state_t  sb_state, sb_next;

  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic [1:0]  dmcontrol;
  logic [31:0] sbaddress0, sbdata0;
  logic        sbbusyerror, sbreadonaddr, sbautoincrement, sbreadondata;
  logic [2:0]  sberror;

  logic        exec, sb_busy, sb_blocked, busy_hit;
  logic        trig_wr, trig_rd, trig_unaligned;
  logic [31:0] trig_addr, sbcs_val, reg_rdata, rsp_data;
  logic [1:0]  rsp_code;
  logic        sb_done, rd_done, sb_timeout;

  assign wmask    = 4'hF;
  assign exec     = (dmi_state == DMI_EXEC);
  assign sb_busy  = (sb_state != SB_IDLE);
  assign sb_blocked = sbbusyerror || (sberror != 3'd0);
  assign busy_hit = exec && sb_busy && (req_op == OP_RD || req_op == OP_WR) &&
                    (req_addr == A_SBADDR0 || req_addr == A_SBDATA0);

  // The read-on-address trigger uses the freshly written address, not the stored one.
  assign trig_wr = exec && !sb_busy && !sb_blocked && req_op == OP_WR && req_addr == A_SBDATA0;
  assign trig_rd = exec && !sb_busy && !sb_blocked &&
                   ((req_op == OP_WR && req_addr == A_SBADDR0 && sbreadonaddr) ||
                    (req_op == OP_RD && req_addr == A_SBDATA0 && sbreadondata));
  assign trig_addr      = (req_addr == A_SBADDR0) ? req_data : sbaddress0;
  assign trig_unaligned = (trig_addr[1:0] != 2'd0);

  assign sbcs_val = {3'd1, 6'd0, sbbusyerror, sb_busy, sbreadonaddr, 3'd2,
                     sbautoincrement, sbreadondata, sberror, 6'd0, 6'h24};

  always_comb begin
    reg_rdata = '0;
    case (req_addr)
      A_DMCONTROL: reg_rdata = {30'd0, dmcontrol};
      A_DMSTATUS:  reg_rdata = DMSTATUS_VAL;
      A_SBCS:      reg_rdata = sbcs_val;
      A_SBADDR0:   reg_rdata = sbaddress0;
      A_SBDATA0:   reg_rdata = sbdata0;
      default:     reg_rdata = '0;
    endcase
  end

  always_comb begin
    rsp_data = '0;
    rsp_code = 2'd0;
    if (req_op == OP_RSV)      rsp_code = 2'd2;
    else if (busy_hit)         rsp_code = 2'd3;
    else if (req_op == OP_RD)  rsp_data = reg_rdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) dmi_state <= DMI_IDLE;
    else        dmi_state <= dmi_next;
  end

  always_comb begin
    dmi_next = dmi_state;
    case (dmi_state)
      DMI_IDLE: if (creq_vld && creq_rdy) dmi_next = DMI_EXEC;
      DMI_EXEC: dmi_next = DMI_RESP;
      DMI_RESP: if (cresp_vld && cresp_rdy) dmi_next = DMI_IDLE;
      default:  dmi_next = DMI_IDLE;
    endcase
  end

  // cresp_vld rises one cycle into RESP, giving the two-cycle accept-to-response latency.
  always_ff @(posedge clock) begin
    if (!reset) begin
      creq_rdy   <= 1'b0;
      cresp_vld  <= 1'b0;
      cresp_data <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_op     <= '0;
    end else begin
      creq_rdy  <= (dmi_next == DMI_IDLE);
      cresp_vld <= (dmi_state == DMI_RESP) && !(cresp_vld && cresp_rdy);
      if (dmi_state == DMI_IDLE && creq_vld && creq_rdy) begin
        req_addr <= creq_data[40:34];
        req_data <= creq_data[33:2];
        req_op   <= creq_data[1:0];
      end
      if (exec) cresp_data <= {rsp_data, rsp_code};
    end
  end

`ifdef DMI_SB_TIMEOUT_EN
  localparam logic [31:0] SB_TO_LAST = 32'(SB_TIMEOUT - 1);
  logic [31:0] sb_cnt;
  always_ff @(posedge clock) begin
    if (!reset || sb_state == SB_IDLE) sb_cnt <= '0;
    else                               sb_cnt <= sb_cnt + 32'd1;
  end
  assign sb_timeout = sb_busy && (sb_cnt == SB_TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (SB_TIMEOUT != 0);
  assign sb_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) sb_state <= SB_IDLE;
    else        sb_state <= sb_next;
  end

  always_comb begin
    sb_next = sb_state;
    sb_done = 1'b0;
    rd_done = 1'b0;
    case (sb_state)
      SB_IDLE: begin
        if (trig_wr && !trig_unaligned)      sb_next = SB_WR;
        else if (trig_rd && !trig_unaligned) sb_next = SB_RD_A;
      end
      SB_WR:    if ((!waen || wardy) && (!wden || wdrdy)) sb_next = SB_WRESP;
      SB_WRESP: if (wbvld) begin sb_next = SB_IDLE; sb_done = 1'b1; end
      SB_RD_A:  if (rardy) sb_next = SB_RD_D;
      SB_RD_D:  if (rdrdy) begin sb_next = SB_IDLE; sb_done = 1'b1; rd_done = 1'b1; end
      default:  sb_next = SB_IDLE;
    endcase
    if (sb_timeout) begin
      sb_next = SB_IDLE;
      sb_done = 1'b0;
      rd_done = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      waen  <= 1'b0;
      wden  <= 1'b0;
      raen  <= 1'b0;
      rden  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      raddr <= '0;
    end else begin
      if (sb_state == SB_IDLE && sb_next == SB_WR) begin
        waen  <= 1'b1;
        wden  <= 1'b1;
        waddr <= sbaddress0;
        wdata <= req_data;
      end
      if (sb_state == SB_IDLE && sb_next == SB_RD_A) begin
        raen  <= 1'b1;
        raddr <= trig_addr;
      end
      if (sb_state == SB_WR) begin
        if (wardy) waen <= 1'b0;
        if (wdrdy) wden <= 1'b0;
      end
      if (sb_state == SB_RD_A && rardy) begin
        raen <= 1'b0;
        rden <= 1'b1;
      end
      if (sb_state == SB_RD_D && rdrdy) rden <= 1'b0;
      if (sb_timeout) begin
        waen <= 1'b0;
        wden <= 1'b0;
        raen <= 1'b0;
        rden <= 1'b0;
      end
    end
  end

  // Error sets are placed after the DMI writes so a set beats a same-cycle W1C.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dmcontrol       <= '0;
      sbaddress0      <= '0;
      sbdata0         <= '0;
      sbbusyerror     <= 1'b0;
      sbreadonaddr    <= 1'b0;
      sbautoincrement <= 1'b0;
      sbreadondata    <= 1'b0;
      sberror         <= '0;
    end else begin
      if (exec) begin
        if (busy_hit) begin
          sbbusyerror <= 1'b1;
        end else if (req_op == OP_WR) begin
          case (req_addr)
            A_DMCONTROL: dmcontrol <= req_data[1:0];
            A_SBCS: begin
              if (req_data[22]) sbbusyerror <= 1'b0;
              sberror         <= sberror & ~req_data[14:12];
              sbreadonaddr    <= req_data[20];
              sbautoincrement <= req_data[16];
              sbreadondata    <= req_data[15];
            end
            A_SBADDR0: sbaddress0 <= req_data;
            A_SBDATA0: sbdata0    <= req_data;
            default: ;
          endcase
        end
        if ((trig_wr || trig_rd) && trig_unaligned) sberror <= 3'd3;
      end
      if (rd_done) sbdata0 <= rdata;
      if (sb_done && sbautoincrement) sbaddress0 <= sbaddress0 + 32'd4;
      if (sb_timeout) sberror <= 3'd1;
    end
  end

endmodule

// File: tb/tb_dmi_sb_responder.sv
// tb/tb_dmi_sb_responder.sv - directed self-checking bench for dmi_sb_responder.
// Define DMI_SB_TIMEOUT_EN to also exercise the system-bus timeout with SB_TIMEOUT=16.
module tb_dmi_sb_responder;

`ifdef DMI_SB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        creq_vld = 1'b0;
  logic [40:0] creq_data = '0;
  logic        creq_rdy;
  logic        cresp_vld;
  logic [33:0] cresp_data;
  logic        cresp_rdy = 1'b0;
  logic        waen, wden, raen, rden;
  logic [31:0] waddr, wdata, raddr;
  logic [3:0]  wmask;
  logic        wardy = 1'b0, wdrdy = 1'b0, wbvld = 1'b0;
  logic        rardy = 1'b0, rdrdy = 1'b0;
  logic [31:0] rdata = '0;

  int err_cnt = 0;
  int chk_cnt = 0;
  int last_lat = 0;

  logic        hold_wa = 1'b0, hold_rd = 1'b0;
  logic        wa_done = 1'b0, wd_done = 1'b0;
  logic [31:0] mem_val = '0;
  logic [31:0] cap_waddr = '0, cap_wdata = '0, cap_raddr = '0;
  logic [3:0]  cap_wmask = '0;
  int          waen_seen = 0, ra_cnt = 0, act_cnt = 0;

  dmi_sb_responder #(.DMSTATUS_VAL(32'h0000_0C82), .SB_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .creq_vld(creq_vld), .creq_data(creq_data), .creq_rdy(creq_rdy),
    .cresp_vld(cresp_vld), .cresp_data(cresp_data), .cresp_rdy(cresp_rdy),
    .waen(waen), .waddr(waddr), .wden(wden), .wdata(wdata), .wmask(wmask),
    .wardy(wardy), .wdrdy(wdrdy), .wbvld(wbvld),
    .raen(raen), .raddr(raddr), .rden(rden), .rdata(rdata),
    .rardy(rardy), .rdrdy(rdrdy)
  );

  always #5 clock = ~clock;

  // Memory-side model: handshakes each request at the next edge, then pulses wbvld.
  always @(negedge clock) begin
    wbvld = 1'b0;
    if (wa_done && wd_done && !waen && !wden) begin
      wbvld   = 1'b1;
      wa_done = 1'b0;
      wd_done = 1'b0;
    end
    wardy = waen && !hold_wa;
    wdrdy = wden;
    rardy = raen;
    rdrdy = rden && !hold_rd;
    rdata = mem_val;
    if (waen) waen_seen++;
    if (waen && !hold_wa) begin wa_done = 1'b1; cap_waddr = waddr; end
    if (wden) begin wd_done = 1'b1; cap_wdata = wdata; cap_wmask = wmask; end
    if (raen) begin ra_cnt++; cap_raddr = raddr; end
    if (raen || rden) act_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                     output logic [33:0] r);
    int n;
    @(negedge clock);
    creq_vld  = 1'b1;
    creq_data = {a, d, op};
    n = 0;
    while (!creq_rdy && n < 100) begin @(negedge clock); n++; end
    if (!creq_rdy) check("dmi_accept_timeout", 0, 1);
    @(posedge clock);
    #1 creq_vld = 1'b0;
    last_lat = 0;
    do begin
      @(posedge clock);
      last_lat++;
      @(negedge clock);
    end while (!cresp_vld && last_lat < 100);
    if (!cresp_vld) check("dmi_resp_timeout", 0, 1);
    r = cresp_data;
    cresp_rdy = 1'b1;
    @(posedge clock);
    #1 cresp_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [33:0] r;
    int n;
    n = 0;
    do begin dmi(7'h38, 2'd1, 32'd0, r); n++; end while (r[23] && n < 20);
    check(tag, r[23], 0);
  endtask

  initial begin
    logic [33:0] r;
    int seen;

    repeat (3) @(negedge clock);
    check("rst_creq_rdy", creq_rdy, 0);
    check("rst_cresp_vld", cresp_vld, 0);
    check("rst_cresp_data", cresp_data, 0);
    check("rst_bus_en", {waen, wden, raen, rden}, 0);
    check("rst_addr", {waddr, raddr}, 0);
    check("rst_wdata", wdata, 0);
    reset = 1'b1;

    dmi(7'h11, 2'd1, 32'd0, r);
    check("dmstatus", r, 34'h3208);
    check("dmstatus_lat", last_lat, 2);
    @(negedge clock);
    check("b2b_rdy", creq_rdy, 1);
    dmi(7'h10, 2'd1, 32'd0, r);
    check("dmcontrol_rst", r, 0);
    dmi(7'h10, 2'd2, 32'hFFFF_FFFF, r);
    check("dmcontrol_wr_resp", r, 0);
    dmi(7'h10, 2'd1, 32'd0, r);
    check("dmcontrol_rd", r, 34'hC);
    dmi(7'h11, 2'd3, 32'd0, r);
    check("reserved_op", r, 34'h2);
    dmi(7'h20, 2'd1, 32'd0, r);
    check("unmapped_rd", r, 0);
    dmi(7'h38, 2'd1, 32'd0, r);
    check("sbcs_fixed", {r[33:31], r[21:19], r[23], r[4]}, {3'd1, 3'd2, 1'b0, 1'b1});

    // SB write with autoincrement
    dmi(7'h38, 2'd2, 32'h0001_0000, r);
    dmi(7'h39, 2'd2, 32'h0000_0100, r);
    dmi(7'h3C, 2'd2, 32'hDEAD_BEEF, r);
    check("sbwr_resp", r, 0);
    wait_idle("sbwr_idle");
    check("sbwr_waddr", cap_waddr, 32'h100);
    check("sbwr_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("sbwr_wmask", cap_wmask, 4'hF);
    dmi(7'h39, 2'd1, 32'd0, r);
    check("sbwr_autoinc", r, {32'h104, 2'd0});

    // SB read on address, then read on data
    ra_cnt  = 0;
    mem_val = 32'h1234_5678;
    dmi(7'h38, 2'd2, 32'h0010_8000, r);
    dmi(7'h39, 2'd2, 32'h0000_0200, r);
    wait_idle("sbrd_idle1");
    check("sbrd_raddr1", cap_raddr, 32'h200);
    mem_val = 32'hCAFE_F00D;
    dmi(7'h3C, 2'd1, 32'd0, r);
    check("sbrd_data1", r, {32'h1234_5678, 2'd0});
    wait_idle("sbrd_idle2");
    check("sbrd_cnt", ra_cnt, 2);
    check("sbrd_raddr2", cap_raddr, 32'h200);
    dmi(7'h3C, 2'd1, 32'd0, r);
    check("sbrd_data2", r, {32'hCAFE_F00D, 2'd0});
    wait_idle("sbrd_idle3");
    dmi(7'h39, 2'd1, 32'd0, r);
    check("sbrd_noinc", r, {32'h200, 2'd0});

    // Busy error
    dmi(7'h38, 2'd2, 32'h0000_0000, r);
    hold_wa = 1'b1;
    dmi(7'h3C, 2'd2, 32'h0000_0055, r);
    check("busy_first_resp", r, 0);
    dmi(7'h39, 2'd2, 32'h0000_0300, r);
    check("busy_resp", r, 34'h3);
    dmi(7'h38, 2'd1, 32'd0, r);
    check("busy_sbcs", {r[24], r[23]}, 2'b11);
    hold_wa = 1'b0;
    repeat (5) @(negedge clock);
    check("busy_waddr", cap_waddr, 32'h200);
    check("busy_wdata", cap_wdata, 32'h55);
    dmi(7'h39, 2'd1, 32'd0, r);
    check("busy_addr_kept", r, {32'h200, 2'd0});
    dmi(7'h38, 2'd2, 32'h0040_0000, r);
    dmi(7'h38, 2'd1, 32'd0, r);
    check("busyerr_w1c", {r[24], r[23]}, 2'b00);

    // Unaligned address and blocking until W1C
    dmi(7'h39, 2'd2, 32'h0000_0102, r);
    seen = waen_seen;
    dmi(7'h3C, 2'd2, 32'h0000_0001, r);
    repeat (5) @(negedge clock);
    check("unal_nobus", waen_seen, seen);
    dmi(7'h38, 2'd1, 32'd0, r);
    check("unal_sberror", r[16:14], 3'd3);
    dmi(7'h39, 2'd2, 32'h0000_0100, r);
    dmi(7'h3C, 2'd2, 32'h0000_0002, r);
    repeat (5) @(negedge clock);
    check("blocked_nobus", waen_seen, seen);
    dmi(7'h38, 2'd2, 32'h0000_7000, r);
    dmi(7'h38, 2'd1, 32'd0, r);
    check("sberror_w1c", r[16:14], 3'd0);
    dmi(7'h3C, 2'd2, 32'h0000_0077, r);
    wait_idle("unblk_idle");
    check("unblk_bus", waen_seen, seen + 1);
    check("unblk_wdata", {cap_waddr, cap_wdata}, {32'h100, 32'h77});

`ifdef DMI_SB_TIMEOUT_EN
    dmi(7'h38, 2'd2, 32'h0010_0000, r);
    hold_rd = 1'b1;
    act_cnt = 0;
    dmi(7'h39, 2'd2, 32'h0000_0400, r);
    repeat (30) @(negedge clock);
    check("to_active_cycles", act_cnt, 16);
    check("to_rden", rden, 0);
    dmi(7'h38, 2'd1, 32'd0, r);
    check("to_sberror", r[16:14], 3'd1);
    check("to_busy", r[23], 0);
    hold_rd = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
